pmu_seq: RTL and testbench

//  Power-mode sequencer for the mcu51 core. Runs on the always-on clock.

---
 rtl/pmu_seq.sv | 118 +++++++++++
 tb/tb_pmu_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pmu_seq.sv
// Power-mode sequencer: turns PCON IDLE/STOP pulses into clock/oscillator enables
// and times the oscillator warm-up before resuming from STOP.
module pmu_seq #(
    parameter int                WARM_W   = 8,
    parameter logic [WARM_W-1:0] WARM_CNT = WARM_W'(200)
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       pmuintreq,
    input  logic       idle_req,
    input  logic       stop_req,
    output logic       cpu_clk_en,
    output logic       per_clk_en,
    output logic       osc_en,
    output logic       wake_o,
    output logic [2:0] pmu_state
);

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        IDLE   = 3'd1,
        STOPG  = 3'd2,
        STOP   = 3'd3,
        WARM   = 3'd4,
        RESUME = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [WARM_W-1:0] cnt_q, cnt_d;
    logic              req_r;
    logic              cpu_d, per_d, osc_d, wake_d;

    // Next-state logic; every wake decision uses the registered request.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            RUN: begin
                if (!req_r) begin
                    if (stop_req)      state_d = STOPG;
                    else if (idle_req) state_d = IDLE;
                end
            end
            IDLE: begin
                if (req_r) state_d = RESUME;
            end
            STOPG: begin
                state_d = req_r ? RESUME : STOP;
            end
            STOP: begin
                if (req_r) begin
                    state_d = WARM;
                    cnt_d   = WARM_CNT;
                end
            end
            WARM: begin
                if (cnt_q == '0) state_d = RESUME;
                else             cnt_d   = cnt_q - WARM_W'(1);
            end
            RESUME:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Output decode from the next state so the enables are registered with it.
    always_comb begin
        cpu_d  = 1'b1;
        per_d  = 1'b1;
        osc_d  = 1'b1;
        wake_d = 1'b0;
        case (state_d)
            IDLE:   cpu_d = 1'b0;
            STOPG: begin
                cpu_d = 1'b0;
                per_d = 1'b0;
            end
            STOP: begin
                cpu_d = 1'b0;
                per_d = 1'b0;
                osc_d = 1'b0;
            end
            WARM: begin
                cpu_d = 1'b0;
                per_d = 1'b0;
            end
            RESUME: wake_d = 1'b1;
            default: begin
                cpu_d  = 1'b1;
                per_d  = 1'b1;
                osc_d  = 1'b1;
                wake_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            req_r      <= 1'b0;
            cpu_clk_en <= 1'b1;
            per_clk_en <= 1'b1;
            osc_en     <= 1'b1;
            wake_o     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_r      <= pmuintreq;
            cpu_clk_en <= cpu_d;
            per_clk_en <= per_d;
            osc_en     <= osc_d;
            wake_o     <= wake_d;
        end
    end

    assign pmu_state = state_q;

endmodule

// File: tb/tb_pmu_seq.sv
// Directed bench for pmu_seq with a short warm-up (WARM_CNT=4); outputs are
// checked once per cycle as {cpu, per, osc, wake, state}.
module tb_pmu_seq;

    localparam logic [6:0] E_RUN    = 7'b1110_000;
    localparam logic [6:0] E_IDLE   = 7'b0110_001;
    localparam logic [6:0] E_STOPG  = 7'b0010_010;
    localparam logic [6:0] E_STOP   = 7'b0000_011;
    localparam logic [6:0] E_WARM   = 7'b0010_100;
    localparam logic [6:0] E_RESUME = 7'b1111_101;

    logic       clk = 1'b0;
    logic       rstn;
    logic       pmuintreq, idle_req, stop_req;
    logic       cpu_clk_en, per_clk_en, osc_en, wake_o;
    logic [2:0] pmu_state;
    int         checks = 0;
    int         failures = 0;

    pmu_seq #(.WARM_W(8), .WARM_CNT(8'd4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .pmuintreq  (pmuintreq),
        .idle_req   (idle_req),
        .stop_req   (stop_req),
        .cpu_clk_en (cpu_clk_en),
        .per_clk_en (per_clk_en),
        .osc_en     (osc_en),
        .wake_o     (wake_o),
        .pmu_state  (pmu_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic idl, input logic stp, input logic irq);
        idle_req  = idl;
        stop_req  = stp;
        pmuintreq = irq;
    endtask

    task automatic checkOutput(input string tag, input logic [6:0] expected);
        logic [6:0] observed;
        observed = {cpu_clk_en, per_clk_en, osc_en, wake_o, pmu_state};
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Takes a STOP-state DUT through wake, the 5-cycle warm-up, RESUME and back to RUN.
    task automatic wakeFromStop(input string tag);
        applyStimulus(0, 0, 1);
        checkOutput({tag, "_stop_irq"}, E_STOP);
        step();
        applyStimulus(0, 0, 0);
        checkOutput({tag, "_stop_reqr"}, E_STOP);
        step();
        for (int i = 0; i < 5; i++) begin
            checkOutput({tag, "_warm"}, E_WARM);
            step();
        end
        checkOutput({tag, "_resume"}, E_RESUME);
        step();
        checkOutput({tag, "_run"}, E_RUN);
    endtask

    initial begin
        applyStimulus(0, 0, 0);
        rstn = 1'b0;
        #12;
        checkOutput("reset", E_RUN);
        rstn = 1'b1;
        step();
        checkOutput("post_reset", E_RUN);
        step();

        // IDLE entry, wake two cycles after pmuintreq
        applyStimulus(1, 0, 0);
        checkOutput("t1_run", E_RUN);
        step();
        applyStimulus(0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            if (i == 4) applyStimulus(0, 1, 0);
            else        applyStimulus(0, 0, 0);
            checkOutput("t1_idle", E_IDLE);
            step();
        end
        applyStimulus(0, 0, 1);
        checkOutput("t1_idle_irq", E_IDLE);
        step();
        applyStimulus(0, 0, 0);
        checkOutput("t1_idle_reqr", E_IDLE);
        step();
        checkOutput("t1_resume", E_RESUME);
        step();
        checkOutput("t1_run_after", E_RUN);
        step();

        // STOP entry, long sleep with stray idle_req, timed warm-up
        applyStimulus(0, 1, 0);
        checkOutput("t2_run", E_RUN);
        step();
        applyStimulus(0, 0, 0);
        checkOutput("t2_stopg", E_STOPG);
        step();
        for (int i = 0; i < 18; i++) begin
            if (i == 5) applyStimulus(1, 0, 0);
            else        applyStimulus(0, 0, 0);
            checkOutput("t2_stop", E_STOP);
            step();
        end
        wakeFromStop("t2");
        step();

        // Simultaneous requests: STOP wins
        applyStimulus(1, 1, 0);
        checkOutput("t3_run", E_RUN);
        step();
        applyStimulus(0, 0, 0);
        checkOutput("t3_stopg", E_STOPG);
        step();
        checkOutput("t3_stop", E_STOP);
        step();
        wakeFromStop("t3");
        step();

        // Pending wakeup drops both request kinds
        applyStimulus(0, 0, 1);
        checkOutput("t4_run_irq", E_RUN);
        step();
        applyStimulus(1, 0, 1);
        checkOutput("t4_idle_req", E_RUN);
        step();
        applyStimulus(0, 1, 1);
        checkOutput("t4_idle_dropped", E_RUN);
        step();
        applyStimulus(0, 0, 0);
        checkOutput("t4_stop_dropped", E_RUN);
        step();
        checkOutput("t4_still_run", E_RUN);
        step();

        // Wakeup arriving during the clock-off margin skips STOP
        applyStimulus(0, 1, 1);
        checkOutput("t5_run", E_RUN);
        step();
        applyStimulus(0, 0, 0);
        checkOutput("t5_stopg", E_STOPG);
        step();
        checkOutput("t5_resume", E_RESUME);
        step();
        checkOutput("t5_run_after", E_RUN);
        step();

        // Async reset in the middle of warm-up
        applyStimulus(0, 1, 0);
        step();
        applyStimulus(0, 0, 0);
        checkOutput("t6_stopg", E_STOPG);
        step();
        applyStimulus(0, 0, 1);
        step();
        applyStimulus(0, 0, 0);
        step();
        checkOutput("t6_warm_c4", E_WARM);
        step();
        checkOutput("t6_warm_c3", E_WARM);
        step();
        checkOutput("t6_warm_c2", E_WARM);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("t6_async_reset", E_RUN);
        step();
        checkOutput("t6_in_reset", E_RUN);
        #2;
        rstn = 1'b1;
        step();
        checkOutput("t6_release", E_RUN);
        step();
        checkOutput("t6_release2", E_RUN);
        step();
        checkOutput("t6_release3", E_RUN);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
